// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank controller: command encodings, FSM states
// and the command-to-j/k mapping.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_APPLY = 2'b01,
        ST_DONE  = 2'b10
    } st_t;

    // Returns {j,k} for a command.
    function automatic logic [1:0] jk_of(input logic [1:0] cmd);
        logic [1:0] jk;
        case (cmd)
            JK_CLR:  jk = 2'b01;
            JK_SET:  jk = 2'b10;
            JK_TGL:  jk = 2'b11;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_ff.sv
// Plain JK flip-flop: 00 hold, 01 clear, 10 set, 11 toggle on the rising edge.
module jk_ff (
    input  logic j,
    input  logic k,
    input  logic clk,
    output logic q
);

    always_ff @(posedge clk) begin
        case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
        endcase
    end

endmodule

// File: rtl/jk_arb_ctrl.sv
// Two-requester round-robin controller applying hold/clear/set/toggle commands
// to one bit of a jk_ff bank, one command per IDLE->APPLY->DONE pass.
module jk_arb_ctrl
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDXW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [1:0]       cmd0,
    input  logic [IDXW-1:0]  idx0,
    input  logic             req1,
    input  logic [1:0]       cmd1,
    input  logic [IDXW-1:0]  idx1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q
);

    st_t             state, state_nxt;
    logic            rr;        // 1: requester 1 wins a tie
    logic            win;       // requester owning the current command
    logic [1:0]      cur_cmd;
    logic [IDXW-1:0] cur_idx;
    logic            take;
    logic            win_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        win_nxt   = req1 & (~req0 | rr);
        case (state)
            ST_IDLE: begin
                if (req0 | req1) begin
                    take      = 1'b1;
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Winner's command is captured at acceptance so j/k never see req/cmd/idx directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr      <= 1'b0;
            win     <= 1'b0;
            cur_cmd <= JK_HOLD;
            cur_idx <= '0;
        end else if (take) begin
            rr      <= ~win_nxt;
            win     <= win_nxt;
            cur_cmd <= win_nxt ? cmd1 : cmd0;
            cur_idx <= win_nxt ? idx1 : idx0;
        end
    end

    assign busy = (state == ST_APPLY);
    assign done = (state == ST_DONE);
    assign gnt0 = busy & ~win;
    assign gnt1 = busy &  win;

    // An out-of-range index matches no bit, so the handshake runs with q untouched.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic bj, bk;
        logic hit;

        assign hit = busy && (cur_idx == IDXW'(i));

        always_comb begin
            {bj, bk} = 2'b00;
            if (rst)      {bj, bk} = 2'b01;
            else if (hit) {bj, bk} = jk_of(cur_cmd);
        end

        jk_ff u_ff (
            .j   (bj),
            .k   (bk),
            .clk (clk),
            .q   (q[i])
        );
    end

endmodule

// File: tb/tb_jk_arb_ctrl.sv
// Directed bench for jk_arb_ctrl: expected bank values are queued at issue
// and checked when done pulses; a WIDTH=3 instance covers the out-of-range index.
module tb_jk_arb_ctrl;
    import jk_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0, req1;
    logic [1:0] cmd0, cmd1, idx0, idx1;
    logic       gnt0, gnt1, busy, done;
    logic [3:0] q;

    logic       t_req0, t_req1;
    logic [1:0] t_cmd0, t_cmd1, t_idx0, t_idx1;
    logic       t_gnt0, t_gnt1, t_busy, t_done;
    logic [2:0] t_q;

    jk_arb_ctrl #(.WIDTH(4), .IDXW(2)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .cmd0(cmd0), .idx0(idx0),
        .req1(req1), .cmd1(cmd1), .idx1(idx1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .q(q)
    );

    jk_arb_ctrl #(.WIDTH(3), .IDXW(2)) dut3 (
        .clk(clk), .rst(rst),
        .req0(t_req0), .cmd0(t_cmd0), .idx0(t_idx0),
        .req1(t_req1), .cmd1(t_cmd1), .idx1(t_idx1),
        .gnt0(t_gnt0), .gnt1(t_gnt1), .busy(t_busy), .done(t_done), .q(t_q)
    );

    int         ncmp = 0;
    int         nfail = 0;
    int         cyc = 0;
    int         last_done = 0;
    logic [3:0] mq, mq3;
    logic [3:0] exp_q[$];
    int         exp_g[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] apply(input logic [3:0] v, input logic [1:0] c,
                                         input int i, input int w);
        logic [3:0] r;
        r = v;
        if (i < w) begin
            case (c)
                JK_CLR:  r[i] = 1'b0;
                JK_SET:  r[i] = 1'b1;
                JK_TGL:  r[i] = ~r[i];
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic do_cmd(input int d, input int r, input logic [1:0] c,
                          input logic [1:0] i, input string tag);
        int   n;
        logic g, og;
        logic [3:0] e;
        if (d == 1) begin
            mq3 = apply(mq3, c, int'(i), 3);
            exp_q.push_back(mq3);
            t_req0 = 1'b1; t_cmd0 = c; t_idx0 = i;
        end else begin
            mq = apply(mq, c, int'(i), 4);
            exp_q.push_back(mq);
            if (r == 0) begin req0 = 1'b1; cmd0 = c; idx0 = i; end
            else        begin req1 = 1'b1; cmd1 = c; idx1 = i; end
        end
        n = 0; g = 1'b0; og = 1'b0;
        while (!g && n < 8) begin
            @(negedge clk);
            n++;
            g  = (d == 1) ? t_gnt0 : ((r == 0) ? gnt0 : gnt1);
            og = (d == 1) ? t_gnt1 : ((r == 0) ? gnt1 : gnt0);
        end
        t_req0 = 1'b0; req0 = 1'b0; req1 = 1'b0;
        chk({tag, "_gnt_latency"}, 32'(n), 32'(1));
        chk({tag, "_busy"}, 32'((d == 1) ? t_busy : busy), 32'(1));
        chk({tag, "_other_gnt"}, 32'(og), 32'(0));
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, "_done"}, 32'((d == 1) ? t_done : done), 32'(1));
        chk({tag, "_busy_off"}, 32'((d == 1) ? t_busy : busy), 32'(0));
        chk({tag, "_q"}, (d == 1) ? 32'(t_q) : 32'(q), 32'(e));
        last_done = cyc;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'((d == 1) ? t_done : done), 32'(0));
    endtask

    initial begin
        int   n;
        int   d1;
        logic w;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; cmd0 = '0; cmd1 = '0; idx0 = '0; idx1 = '0;
        t_req0 = 1'b0; t_req1 = 1'b0; t_cmd0 = '0; t_cmd1 = '0; t_idx0 = '0; t_idx1 = '0;
        mq = '0; mq3 = '0;

        // Reset from unknown bank state
        repeat (2) @(negedge clk);
        chk("rst_q", 32'(q), 32'(4'b0000));
        chk("rst_q3", 32'(t_q), 32'(3'b000));
        chk("rst_gnt", 32'({gnt0, gnt1}), 32'(0));
        chk("rst_busy_done", 32'({busy, done}), 32'(0));
        rst = 1'b0;

        do_cmd(0, 0, JK_SET, 2'd2, "set2");
        chk("set2_lit", 32'(q), 32'(4'b0100));

        do_cmd(0, 1, JK_TGL, 2'd0, "tgl_a");
        d1 = last_done;
        do_cmd(0, 1, JK_TGL, 2'd0, "tgl_b");
        chk("tgl_spacing", 32'(last_done - d1), 32'(3));
        chk("tgl_lit", 32'(q), 32'(4'b0100));

        do_cmd(0, 0, JK_HOLD, 2'd1, "hold");
        do_cmd(0, 0, JK_CLR, 2'd2, "clr2");
        do_cmd(0, 0, JK_SET, 2'd3, "set3");
        chk("set3_lit", 32'(q), 32'(4'b1000));
        do_cmd(0, 0, JK_CLR, 2'd3, "clr3");
        chk("clr3_lit", 32'(q), 32'(4'b0000));

        // Out-of-range index on the 3-bit bank
        do_cmd(1, 0, JK_SET, 2'd3, "w3_idx3");
        chk("w3_idx3_lit", 32'(t_q), 32'(3'b000));
        do_cmd(1, 0, JK_SET, 2'd2, "w3_set2");
        chk("w3_set2_lit", 32'(t_q), 32'(3'b100));

        // Contention from reset: both held high, expect 0,1,0,1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq = '0; mq3 = '0;
        exp_g.push_back(0); exp_g.push_back(1); exp_g.push_back(0); exp_g.push_back(1);
        req0 = 1'b1; cmd0 = JK_SET; idx0 = 2'd1;
        req1 = 1'b1; cmd1 = JK_TGL; idx1 = 2'd2;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("no_dual_gnt", 32'(gnt0 & gnt1), 32'(0));
            if (gnt0 | gnt1) begin
                w = gnt1;
                if (exp_g.size() == 0) chk("extra_gnt", 32'(1), 32'(0));
                else                   chk("gnt_order", 32'(w), 32'(exp_g.pop_front()));
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("gnt_count", 32'(exp_g.size()), 32'(0));
        mq = apply(mq, JK_SET, 1, 4);
        mq = apply(mq, JK_TGL, 2, 4);
        mq = apply(mq, JK_SET, 1, 4);
        mq = apply(mq, JK_TGL, 2, 4);
        @(negedge clk);
        chk("contend_q", 32'(q), 32'(mq));

        // Reset during APPLY aborts the command
        req1 = 1'b1; cmd1 = JK_SET; idx1 = 2'd1;
        n = 0;
        while (!gnt1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("abort_gnt_latency", 32'(n), 32'(1));
        req1 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq = '0;
        chk("abort_q", 32'(q), 32'(4'b0000));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_busy_gnt", 32'({busy, gnt0, gnt1}), 32'(0));
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'(0));
        do_cmd(0, 0, JK_SET, 2'd0, "post_rst");
        chk("post_rst_lit", 32'(q), 32'(4'b0001));
        chk("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/jk_arb_ctrl.md
JK_ARB_CTRL -- requirements
Module: jk_arb_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, number of jk_ff bits in the controlled bank.
REQ-002 Parameter: IDXW, default 2, index width; 2**IDXW SHALL be >= WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0  input  1  requester 0 command request, held until gnt0.
REQ-006 cmd0  input  2  requester 0 command: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-007 idx0  input  IDXW  requester 0 target bit index.
REQ-008 req1 / cmd1 / idx1  input  1 / 2 / IDXW  requester 1, same meaning.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse; command accepted.
REQ-010 busy  output  1  high while a command is being applied (state APPLY).
REQ-011 done  output  1  one-cycle pulse: q reflects the applied command.
REQ-012 q  output  WIDTH  bank state, taken directly from the jk_ff instances.

Function
REQ-013 FSM states: IDLE, APPLY, DONE; encoding is binary, 2 bits.
REQ-014 IDLE: if any req is high at an edge, select a winner, register its cmd/idx, assert that gnt for the next cycle, go to APPLY; else stay.
REQ-015 Arbitration: round-robin; with both req high, the requester not granted last wins; a lone requester always wins.
REQ-016 APPLY (1 cycle): drive j/k of bit idx per cmd (hold 0/0, clear 0/1, set 1/0, toggle 1/1); all other bits 0/0; busy=1; gnt of winner=1; next state DONE.
REQ-017 DONE (1 cycle): all j/k 0/0; done=1; busy=0; next state IDLE.
REQ-018 Latency: req sampled at edge n -> gnt/busy high in cycle n..n+1 -> q updated at edge n+1 -> done high cycle n+1..n+2.
REQ-019 Throughput: one command per 3 cycles; a req pending during APPLY/DONE is evaluated again in IDLE.
REQ-020 req dropped before grant: command is discarded, no gnt, no state change.
REQ-021 idx >= WIDTH: command is accepted and granted, j/k all 0/0 (no bit changes), done still pulses.
REQ-022 cmd 00 (hold): full handshake executes, q unchanged.
REQ-023 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-024 While rst is high at an edge: state <= IDLE, rr pointer <= favour req0, gnt0/gnt1/busy/done <= 0.
REQ-025 While rst is high, all jk_ff bits SHALL be driven j=0,k=1, so q=0 after the first reset edge.
REQ-026 rst asserted mid-APPLY or mid-DONE aborts the command: no done pulse, q cleared.

Structure
REQ-027 Shared package jk_pkg: command encodings (JK_HOLD, JK_CLR, JK_SET, JK_TGL) and FSM state constants.
REQ-028 Sub-module: existing jk_ff (ports j, k, clk, q), instantiated WIDTH times by generate loop; no other sub-modules.
REQ-029 Controller j/k drive is combinational from registered state, cmd and idx; no combinational path from req to j/k.

Verification
REQ-030 Reset: rst=1 for 2 cycles from unknown q -> q=4'b0000, gnt/busy/done=0.
REQ-031 Single set: req0=1, cmd0=10, idx0=2 -> gnt0 and busy high 1 cycle, q=4'b0100 with done pulse next cycle.
REQ-032 Toggle twice: req1 cmd=11 idx=0 issued twice back-to-back -> q[0] 0->1->0, two done pulses 3 cycles apart.
REQ-033 Contention: req0 and req1 held high, from reset -> grant order 0,1,0,1; never both gnt.
REQ-034 Boundary: idx0=3 set then idx0=3 clear -> q=4'b1000 then 4'b0000; WIDTH=3 run with idx=3 -> q unchanged, done pulses.
REQ-035 Reset mid-op: rst raised in APPLY after set idx1=1 -> no done, q=4'b0000, next req serviced normally.
